// File: rtl/pc_unit.sv
// Program-counter unit: holds the architectural PC and selects increment, redirect or trap vector.
// Optional compressed (16-bit) instruction support is enabled by defining PC_COMPRESSED_EN.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            compressed_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] next_pc_o,
  output logic            pc_valid_o,
  output logic            misalign_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    StStart   = 2'b00,
    StRun     = 2'b01,
    StHalt    = 2'b10,
    StIllegal = 2'b11
  } state_e;

  state_e          r_state, w_state_d;
  logic [XLEN-1:0] r_pc, w_pc_d;
  logic            r_valid, w_valid_d;
  logic            r_misalign, w_misalign_d;
  logic [XLEN-1:0] w_inc;
  logic            w_aligned;

`ifdef PC_COMPRESSED_EN
  assign w_inc     = compressed_i ? XLEN'(2) : XLEN'(4);
  assign w_aligned = ~redirect_target_i[0];
`else
  logic w_unused_compressed;
  assign w_unused_compressed = compressed_i;
  assign w_inc               = XLEN'(4);
  assign w_aligned           = (redirect_target_i[1:0] == 2'b00);
`endif

  assign next_pc_o = r_pc + w_inc;

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_valid_d    = r_valid;
    w_misalign_d = 1'b0;
    case (r_state)
      StStart: begin
        w_state_d = StRun;
        w_valid_d = 1'b1;
      end
      StRun: begin
        if (trap_i) begin
          w_pc_d = TRAP_VECTOR;
        end else if (redirect_i) begin
          if (w_aligned) begin
            w_pc_d = redirect_target_i;
          end else begin
            w_pc_d       = TRAP_VECTOR;
            w_misalign_d = 1'b1;
          end
        end else if (halt_i) begin
          w_state_d = StHalt;
          w_valid_d = 1'b0;
        end else if (!stall_i) begin
          w_pc_d = next_pc_o;
        end
      end
      StHalt: begin
        if (trap_i) begin
          w_pc_d    = TRAP_VECTOR;
          w_state_d = StRun;
          w_valid_d = 1'b1;
        end else if (resume_i) begin
          w_state_d = StRun;
          w_valid_d = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: fall back to the start-up state.
        w_state_d = StStart;
        w_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StStart;
      r_pc       <= RESET_VECTOR;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_valid    <= w_valid_d;
      r_misalign <= w_misalign_d;
    end
  end

  assign pc_o       = r_pc;
  assign pc_valid_o = r_valid;
  assign misalign_o = r_misalign;
  assign state_o    = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed plan steps followed by random stimulus,
// compared every cycle against a behavioural model of the PC rules.
module tb_pc_unit;

  localparam int unsigned XLEN = 32;
  localparam longint unsigned Mask = 64'h0000_0000_FFFF_FFFF;
  localparam longint unsigned RstVec = 64'h0;
  localparam longint unsigned TrapVec = 64'h100;
  localparam int MStart = 0, MRun = 1, MHalt = 2;

  logic            clk = 1'b0;
  logic            rst, stall_i, redirect_i, trap_i, halt_i, resume_i, compressed_i;
  logic [XLEN-1:0] redirect_target_i;
  logic [XLEN-1:0] pc_o, next_pc_o;
  logic            pc_valid_o, misalign_o;
  logic [1:0]      state_o;

  int checks = 0;
  int failures = 0;

  longint unsigned m_pc;
  int              m_state;
  bit              m_valid, m_mis;

  pc_unit #(
    .XLEN        (XLEN),
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_target_i(redirect_target_i),
    .trap_i           (trap_i),
    .halt_i           (halt_i),
    .resume_i         (resume_i),
    .compressed_i     (compressed_i),
    .pc_o             (pc_o),
    .next_pc_o        (next_pc_o),
    .pc_valid_o       (pc_valid_o),
    .misalign_o       (misalign_o),
    .state_o          (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned inc_now();
`ifdef PC_COMPRESSED_EN
    return compressed_i ? 64'd2 : 64'd4;
`else
    return 64'd4;
`endif
  endfunction

  function automatic bit target_ok(input longint unsigned t);
`ifdef PC_COMPRESSED_EN
    return (t % 2) == 0;
`else
    return (t % 4) == 0;
`endif
  endfunction

  task automatic drive(input bit s, input bit rd, input logic [31:0] tg, input bit tr,
                       input bit hl, input bit rs, input bit cp);
    stall_i = s; redirect_i = rd; redirect_target_i = tg; trap_i = tr;
    halt_i = hl; resume_i = rs; compressed_i = cp;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 0, 0, 0);
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge.
  task automatic tick();
    longint unsigned n_pc = m_pc;
    int n_st = m_state;
    bit n_v = m_valid;
    bit n_m = 1'b0;
    if (rst) begin
      n_pc = RstVec; n_st = MStart; n_v = 0;
    end else if (m_state == MStart) begin
      n_st = MRun; n_v = 1;
    end else if (m_state == MRun) begin
      if (trap_i) n_pc = TrapVec;
      else if (redirect_i) begin
        if (target_ok(longint'(redirect_target_i))) n_pc = longint'(redirect_target_i);
        else begin n_pc = TrapVec; n_m = 1; end
      end else if (halt_i) begin n_st = MHalt; n_v = 0; end
      else if (!stall_i) n_pc = (m_pc + inc_now()) & Mask;
    end else begin
      if (trap_i) begin n_pc = TrapVec; n_st = MRun; n_v = 1; end
      else if (resume_i) begin n_st = MRun; n_v = 1; end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_state = n_st; m_valid = n_v; m_mis = n_m;
    chk("pc", pc_o, m_pc);
    chk("valid", pc_valid_o, m_valid);
    chk("misalign", misalign_o, m_mis);
    chk("state", state_o, m_state);
    chk("next_pc", next_pc_o, (m_pc + inc_now()) & Mask);
  endtask

  initial begin
    m_pc = 0; m_state = MStart; m_valid = 0; m_mis = 0;
    rst = 1; idle();
    tick(); tick();
    chk("reset_pc", pc_o, 32'h0);
    chk("reset_valid", pc_valid_o, 1'b0);
    rst = 0;
    tick();
    chk("first_valid", pc_valid_o, 1'b1);
    chk("first_pc", pc_o, 32'h0);
    tick(); tick();
    chk("idle_pc8", pc_o, 32'h8);

    drive(0, 1, 32'h40, 0, 0, 0, 0); tick();
    chk("redir_40", pc_o, 32'h40);
    drive(0, 1, 32'h42, 0, 0, 0, 0); tick();
`ifndef PC_COMPRESSED_EN
    chk("misalign_pc", pc_o, 32'h100);
    chk("misalign_pulse", misalign_o, 1'b1);
`endif
    idle(); tick();
    chk("misalign_clear", misalign_o, 1'b0);

    drive(0, 1, 32'h40, 0, 0, 0, 0); tick();
    drive(1, 0, 32'h0, 0, 0, 0, 0); tick(); tick(); tick();
    chk("stall_hold", pc_o, 32'h40);
    drive(0, 0, 32'h0, 0, 1, 0, 0); tick();
    chk("halt_state", state_o, 2'b10);
    drive(0, 1, 32'h80, 0, 0, 0, 0); tick();
    chk("halt_ignore_redir", pc_o, 32'h40);
    drive(0, 0, 32'h0, 0, 0, 1, 0); tick();
    chk("resume_pc", pc_o, 32'h40);
    idle(); tick();
    chk("resume_inc", pc_o, 32'h44);

    drive(0, 1, 32'h42, 1, 0, 0, 0); tick();
    chk("trap_wins_pc", pc_o, 32'h100);
    chk("trap_wins_mis", misalign_o, 1'b0);
    drive(0, 0, 32'h0, 0, 1, 0, 0); tick();
    idle(); rst = 1; tick();
    chk("rst_halt_pc", pc_o, 32'h0);
    chk("rst_halt_state", state_o, 2'b00);
    rst = 0; tick();

    drive(0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0); tick();
    idle(); tick(); tick();
    chk("wrap", pc_o, 32'h0);

`ifdef PC_COMPRESSED_EN
    drive(0, 1, 32'h10, 0, 0, 0, 0); tick();
    drive(0, 0, 32'h0, 0, 0, 0, 1); #1;
    chk("c_next_pc", next_pc_o, 32'h12);
    tick();
    chk("c_pc", pc_o, 32'h12);
    drive(0, 1, 32'h22, 0, 0, 0, 0); tick();
    chk("c_redir", pc_o, 32'h22);
    chk("c_redir_mis", misalign_o, 1'b0);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [31:0] tg;
      tg = $urandom;
      if ($urandom_range(1, 0) == 1) tg[1:0] = 2'b00;
      rst = ($urandom_range(99, 0) < 2);
      drive($urandom_range(99, 0) < 20, $urandom_range(99, 0) < 15, tg,
            $urandom_range(99, 0) < 5, $urandom_range(99, 0) < 6,
            $urandom_range(99, 0) < 25, $urandom_range(1, 0) == 1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle RISC-V core, generalising the fixed PC+4 incrementer. It holds the architectural PC in a register and selects the next value from sequential increment, branch/jump redirect or trap vector. It also supports stall, halt/resume, a post-reset start-up state and misaligned-target detection. The unit sits at the front of the datapath, feeding instruction memory and the link-address path.

## Interface
Parameters:
- XLEN, 32, datapath/PC width in bits (≥ 8).
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset (XLEN bits).
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect.

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-high reset.
- stall_i, input, 1, hold PC this cycle.
- redirect_i, input, 1, take redirect_target_i (branch/jump).
- redirect_target_i, input, XLEN, redirect destination.
- trap_i, input, 1, take TRAP_VECTOR.
- halt_i, input, 1, enter HALT.
- resume_i, input, 1, leave HALT.
- compressed_i, input, 1, current instruction is 16-bit (used only with PC_COMPRESSED_EN).
- pc_o, output, XLEN, registered current PC.
- next_pc_o, output, XLEN, combinational pc_o + INC (link address).
- pc_valid_o, output, 1, registered; pc_o is a valid fetch address.
- misalign_o, output, 1, registered one-cycle pulse; misaligned redirect was trapped.
- state_o, output, 2, registered FSM state.

## Operation
- INC = 4, or 2 when PC_COMPRESSED_EN is defined and compressed_i=1. Addition is modulo 2^XLEN; wrap from all-ones region to low addresses is silent.
- States: START=2'b00, RUN=2'b01, HALT=2'b10. 2'b11 is unreachable and recovers to START on the next clock.
- Reset: pc_o=RESET_VECTOR, state START, pc_valid_o=0, misalign_o=0. rst dominates every other input, including mid-stall, mid-halt and mid-redirect.
- START: unconditionally go to RUN next cycle. pc_o holds RESET_VECTOR, pc_valid_o→1. All other inputs are ignored.
- RUN, priority high→low:
  - trap_i: pc←TRAP_VECTOR.
  - redirect_i with aligned target: pc←redirect_target_i.
  - redirect_i with misaligned target: pc←TRAP_VECTOR, misalign_o←1.
  - halt_i: state←HALT, pc holds, pc_valid_o←0.
  - stall_i: pc holds.
  - Otherwise: pc←pc+INC.
- HALT:
  - trap_i: pc←TRAP_VECTOR, state←RUN, pc_valid_o←1.
  - else resume_i: state←RUN, pc holds, pc_valid_o←1.
  - redirect_i, stall_i and halt_i are ignored.
- Alignment check: target[1:0]==0, or target[0]==0 with PC_COMPRESSED_EN.
- misalign_o is 0 in every cycle not immediately following a misaligned redirect.

## Timing
- Every control input takes effect at the next rising edge: one-cycle latency to pc_o, pc_valid_o, misalign_o and state_o.
- next_pc_o has zero latency from pc_o and no dependence on control inputs other than compressed_i.
- First valid fetch: pc_valid_o=1 in the second cycle after rst deasserts, with pc_o=RESET_VECTOR.
- Simultaneous trap_i and redirect_i: trap wins and misalign_o stays 0. Simultaneous halt_i and redirect_i in RUN: redirect taken, no halt.

## Configuration
- PC_COMPRESSED_EN defined: compressed_i selects INC=2 or 4, and redirect alignment is 2-byte.
- PC_COMPRESSED_EN undefined: compressed_i is ignored, INC is always 4, and redirect alignment is 4-byte. The port still exists.

## Test plan
- Reset then run 3 cycles idle: pc_o = 0x0 (valid=0), 0x0 (valid=1), 0x4, 0x8; next_pc_o tracks pc_o+4.
- From pc 0x8, redirect_i=1 with target 0x40: pc_o=0x40 next cycle. With target 0x42 (no macro): pc_o=0x100 and misalign_o=1 for exactly one cycle.
- stall_i high 3 cycles at pc 0x40: pc_o holds 0x40. Then halt_i: state_o=2'b10 and pc_valid_o=0. redirect_i while halted is ignored. resume_i: RUN, pc_o=0x40, then 0x44.
- trap_i and redirect_i together (target 0x42): pc_o=0x100, misalign_o=0. Assert rst mid-HALT: pc_o=0x0 and state START next cycle.
- XLEN=32 with pc at 0xFFFF_FFFC, idle: pc_o wraps to 0x0000_0000.
- PC_COMPRESSED_EN defined, pc 0x10, compressed_i=1: next_pc_o=0x12 and pc_o=0x12 next cycle. Redirect to 0x22 is accepted with misalign_o=0.
